// File: rtl/subpel_interp_pipe.sv
// subpel_interp_pipe: separable 8-tap quarter-pel interpolator, row-streamed in, row-streamed out
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   in_valid/in_ready/in_row reference rows, NUM_PIXEL+7 pixels each, pixel j at [j*PIX_W +: PIX_W]
//   frac_x, frac_y           quarter-pel phases, taken from the first accepted row of a block
//   out_valid/out_ready      output row handshake
//   out_data, out_row        interpolated row (pixel c at [c*PIX_W +: PIX_W]) and its index
//   busy                     high whenever a block is being loaded or emitted
module subpel_interp_pipe #(
    parameter int NUM_PIXEL = 8,
    parameter int PIX_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [(NUM_PIXEL+7)*PIX_W-1:0] in_row,
    input  logic [1:0]                     frac_x,
    input  logic [1:0]                     frac_y,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_PIXEL*PIX_W-1:0]     out_data,
    output logic [7:0]                     out_row,
    output logic                           busy
);
    localparam int ROWS = NUM_PIXEL + 7;
    localparam int RW   = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int AW   = PIX_W + 9;
    localparam logic [RW-1:0] LAST_IN  = RW'(ROWS - 1);
    localparam logic [7:0]    LAST_OUT = 8'(NUM_PIXEL - 1);
    // Row 0 is never used: phase 0 bypasses the filter.
    localparam logic signed [7:0] COEF [4][8] = '{
        '{8'sd0,  8'sd0, 8'sd0,   8'sd0,  8'sd0,  8'sd0,   8'sd0, 8'sd0},
        '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5,  8'sd1, 8'sd0},
        '{-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1},
        '{8'sd0,  8'sd1, -8'sd5,  8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1}
    };

    typedef enum logic [1:0] {IDLE, LOAD, VERT} state_t;

    // 8-tap filter with rounding and clipping; phase 0 passes tap 3 through untouched.
    function automatic logic [PIX_W-1:0] filt(input logic [1:0] ph, input logic [8*PIX_W-1:0] t);
        logic signed [AW-1:0] acc;
        logic signed [AW-1:0] r;
        acc = AW'(32);
        for (int k = 0; k < 8; k++)
            acc = acc + $signed({9'b0, t[k*PIX_W +: PIX_W]}) * AW'(COEF[ph][k]);
        r = acc >>> 6;
        return ph == 2'd0 ? t[3*PIX_W +: PIX_W] :
               r[AW-1]    ? '0 :
               |r[AW-2:PIX_W] ? '1 : r[PIX_W-1:0];
    endfunction

    state_t            state_q, state_d;
    logic [RW-1:0]     row_q;
    logic [7:0]        out_row_q;
    logic [1:0]        fx_q, fy_q;
    logic [PIX_W-1:0]  mem_q [ROWS][NUM_PIXEL];
    logic [PIX_W-1:0]  hrow  [NUM_PIXEL];
    logic [8*PIX_W-1:0] vtap [NUM_PIXEL];
    logic [RW-1:0]     vidx  [8];
    logic [1:0]        hph;
    logic              acc_in, acc_out, last_in, last_out;

    assign acc_in   = in_valid && in_ready;
    assign acc_out  = out_valid && out_ready;
    assign last_in  = row_q == LAST_IN;
    assign last_out = out_row_q == LAST_OUT;
    assign out_row  = out_row_q;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc_in) state_d = last_in ? VERT : LOAD;
            LOAD:    if (acc_in && last_in) state_d = VERT;
            VERT:    if (acc_out && last_out) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state_q != VERT;
        busy      = state_q != IDLE;
        out_valid = state_q == VERT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q     <= '0;
            out_row_q <= '0;
            fx_q      <= '0;
            fy_q      <= '0;
        end else begin
            if (acc_in)
                row_q <= last_in ? '0 : row_q + RW'(1);
            if (acc_in && state_q == IDLE) begin
                fx_q <= frac_x;
                fy_q <= frac_y;
            end
            if (acc_out)
                out_row_q <= last_out ? '0 : out_row_q + 8'd1;
        end
    end

    // The first row of a block is filtered with the live frac_x, later rows with the latched copy.
    assign hph = state_q == IDLE ? frac_x : fx_q;

    always_ff @(posedge clk) begin
        if (acc_in)
            for (int c = 0; c < NUM_PIXEL; c++)
                mem_q[row_q][c] <= hrow[c];
    end

    for (genvar k = 0; k < 8; k++) begin : g_vidx
        assign vidx[k] = RW'(out_row_q) + RW'(k);
    end

    for (genvar c = 0; c < NUM_PIXEL; c++) begin : g_col
        assign hrow[c] = filt(hph, in_row[c*PIX_W +: 8*PIX_W]);
        for (genvar k = 0; k < 8; k++) begin : g_tap
            assign vtap[c][k*PIX_W +: PIX_W] = mem_q[vidx[k]][c];
        end
        assign out_data[c*PIX_W +: PIX_W] = out_valid ? filt(fy_q, vtap[c]) : '0;
    end
endmodule

// File: tb/tb_subpel_interp_pipe.sv
// tb_subpel_interp_pipe: randomized and directed checks of subpel_interp_pipe (8- and 4-pixel instances)
module tb_subpel_interp_pipe;
    logic clk = 0;
    always #5 clk = ~clk;

    logic         rst, iv, sel, ordy;
    logic [1:0]   fx, fy;
    logic [119:0] row;
    logic         iv0, iv1, ir0, ir1, ov0, ov1, b0, b1;
    logic [7:0]   orw0, orw1;
    logic [63:0]  od0;
    logic [31:0]  od1;
    logic         ir, ov, bz;
    logic [7:0]   orw;
    logic [63:0]  od;

    assign iv0 = iv & ~sel;
    assign iv1 = iv & sel;
    assign ir  = sel ? ir1 : ir0;
    assign ov  = sel ? ov1 : ov0;
    assign bz  = sel ? b1 : b0;
    assign orw = sel ? orw1 : orw0;
    assign od  = sel ? {32'b0, od1} : od0;

    subpel_interp_pipe u8 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_row(row),
        .frac_x(fx), .frac_y(fy), .out_valid(ov0), .out_ready(ordy),
        .out_data(od0), .out_row(orw0), .busy(b0)
    );

    subpel_interp_pipe #(.NUM_PIXEL(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_row(row[87:0]),
        .frac_x(fx), .frac_y(fy), .out_valid(ov1), .out_ready(ordy),
        .out_data(od1), .out_row(orw1), .busy(b1)
    );

    localparam int CF [4][8] = '{
        '{0, 0, 0, 0, 0, 0, 0, 0},
        '{-1, 4, -10, 58, 17, -5, 1, 0},
        '{-1, 4, -11, 40, 40, -11, 4, -1},
        '{0, 1, -5, 17, 58, -10, 4, -1}
    };

    int          n_chk = 0, n_fail = 0;
    int          pix [15][15];
    int          ex  [8][8];
    logic [63:0] first_row;
    int          t_first, t_last;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic int f(input int ph, input int t [8]);
        int s = 32;
        if (ph == 0) return t[3];
        for (int k = 0; k < 8; k++) s += CF[ph][k] * t[k];
        s = s >>> 6;
        return s < 0 ? 0 : s > 255 ? 255 : s;
    endfunction

    function automatic void model(input int np, input int fxp, input int fyp);
        int h [15][8];
        int t [8];
        for (int y = 0; y < np + 7; y++)
            for (int c = 0; c < np; c++) begin
                for (int k = 0; k < 8; k++) t[k] = pix[y][c+k];
                h[y][c] = f(fxp, t);
            end
        for (int r = 0; r < np; r++)
            for (int c = 0; c < np; c++) begin
                for (int k = 0; k < 8; k++) t[k] = h[r+k][c];
                ex[r][c] = f(fyp, t);
            end
    endfunction

    function automatic logic [63:0] pack_exp(input int r, input int np);
        logic [63:0] e = '0;
        for (int c = 0; c < np; c++) e[c*8 +: 8] = 8'(ex[r][c]);
        return e;
    endfunction

    function automatic logic [119:0] pack_row(input int y);
        logic [119:0] v = '0;
        for (int x = 0; x < 15; x++) v[x*8 +: 8] = 8'(pix[y][x]);
        return v;
    endfunction

    task automatic rand_pix();
        for (int y = 0; y < 15; y++)
            for (int x = 0; x < 15; x++) pix[y][x] = int'($urandom_range(255));
    endtask

    task automatic run_block(input logic s, input int fxp, input int fyp, input int vp, input int rp, input int stall_at);
        int np = s ? 4 : 8;
        int rows = np + 7;
        int sent = 0, got = 0, cyc = 0, last_acc = -100, scnt = 0;
        logic [63:0] held_d;
        logic [7:0]  held_r;
        sel = s;
        model(np, fxp, fyp);
        t_first = -1;
        while (got < np && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == last_acc + 1) begin
                chk("first_valid", 64'(ov), 64'd1);
                chk("first_row_idx", 64'(orw), 64'd0);
            end
            if (sent < rows) chk("load_no_valid", 64'(ov), 64'd0);
            if (ov) begin
                if (t_first < 0) t_first = cyc;
                chk("row_idx", 64'(orw), 64'(got));
                if (got == stall_at && scnt < 5) begin
                    if (scnt == 0) begin
                        held_d = od;
                        held_r = orw;
                    end else begin
                        chk("stall_data", od, held_d);
                        chk("stall_row", 64'(orw), 64'(held_r));
                    end
                    scnt++;
                    ordy = 0;
                end else
                    ordy = ($urandom_range(99) < rp);
                if (ordy) begin
                    chk("row_data", od, pack_exp(got, np));
                    if (got == 0) first_row = od;
                    got++;
                    t_last = cyc;
                end
            end else
                ordy = 1'($urandom_range(1));
            if (sent < rows) begin
                chk("ready_load", 64'(ir), 64'd1);
                iv  = ($urandom_range(99) < vp);
                row = pack_row(sent);
                fx  = 2'(sent == 0 ? fxp : int'($urandom));
                fy  = 2'(sent == 0 ? fyp : int'($urandom));
                if (iv) begin
                    sent++;
                    if (sent == rows) last_acc = cyc;
                end
            end else begin
                chk("ready_vert", 64'(ir), 64'd0);
                iv  = 1;
                row = {$urandom, $urandom, $urandom, $urandom};
                fx  = 2'($urandom);
                fy  = 2'($urandom);
            end
        end
        chk("timeout", 64'(got), 64'(np));
        @(posedge clk);
        #1;
        iv = 0;
        chk("idle_ready", 64'(ir), 64'd1);
        chk("idle_busy", 64'(bz), 64'd0);
        chk("idle_valid", 64'(ov), 64'd0);
    endtask

    initial begin
        logic [63:0] e;
        rst = 1; iv = 0; sel = 0; ordy = 0; fx = 0; fy = 0; row = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("rst_ready", 64'(ir), 64'd1);
            chk("rst_busy", 64'(bz), 64'd0);
            chk("rst_valid", 64'(ov), 64'd0);
            chk("rst_row", 64'(orw), 64'd0);
            chk("rst_data", od, 64'd0);
        end
        rst = 0;

        for (int y = 0; y < 15; y++) for (int x = 0; x < 15; x++) pix[y][x] = 100;
        run_block(0, 2, 2, 100, 100, -1);
        chk("flat_t_first", 64'(t_first), 64'd16);
        chk("flat_t_last", 64'(t_last), 64'd23);
        chk("flat_value", first_row, {8{8'd100}});

        for (int y = 0; y < 15; y++) for (int x = 0; x < 15; x++) pix[y][x] = y * 16 + x;
        run_block(0, 0, 0, 100, 100, -1);
        for (int c = 0; c < 8; c++) e[c*8 +: 8] = 8'(3 * 16 + c + 3);
        chk("ramp_row0", first_row, e);

        for (int y = 0; y < 15; y++) for (int x = 0; x < 15; x++) pix[y][x] = (x == 3 || x == 4) ? 255 : 0;
        run_block(0, 2, 0, 100, 100, -1);
        chk("clip_high", 64'(first_row[7:0]), 64'd255);
        for (int y = 0; y < 15; y++) for (int x = 0; x < 15; x++) pix[y][x] = (x == 3 || x == 4) ? 0 : 255;
        run_block(0, 2, 0, 100, 100, -1);
        chk("clip_low", 64'(first_row[7:0]), 64'd0);

        rand_pix();
        run_block(0, 1, 2, 100, 100, 2);

        rand_pix();
        sel = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            iv = 1; row = pack_row(i); fx = 2'(i); fy = 2'(i + 1);
        end
        @(negedge clk);
        iv = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort_ready", 64'(ir), 64'd1);
        chk("abort_busy", 64'(bz), 64'd0);
        chk("abort_valid", 64'(ov), 64'd0);
        chk("abort_row", 64'(orw), 64'd0);
        chk("abort_data", od, 64'd0);
        rand_pix();
        run_block(0, 1, 3, 100, 100, -1);

        for (int i = 0; i < 3; i++) begin
            rand_pix();
            run_block(0, int'($urandom_range(3)), int'($urandom_range(3)), 70, 70, -1);
        end

        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) begin
                rand_pix();
                run_block(1, a, b, 60, 60, -1);
            end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
